mc_sequencer: RTL and testbench

- Multi-cycle control FSM for the RV32 subset datapath (lw, sw, R-ALU, I-ALU, beq, jal).
- Shares one ALU and one unified instruction/data memory across cycles.
- Handles memory wait states via `mem_ready` and traps on illegal opcodes or memory timeouts.
- Sits between the instruction register / zero flag and the datapath muxes and write strobes. It also keeps a retired-instruction counter.

---
 rtl/rv_ctrl_pkg.sv | 55 +++++
 rtl/alu_dec.sv | 34 +++
 rtl/mc_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_mc_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 subset controller: states, opcodes,
// ALU/immediate selects and trap causes.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BEQ:  return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_dec.sv
// ALU control decode: maps aluop/funct3/funct7b5 to the ALU operation and
// flags whether funct3 is one of the supported register/immediate operations.
module alu_dec
    import rv_ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alucontrol,
    output logic       legal
);

    always_comb begin
        legal      = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                     (funct3 == 3'b110) || (funct3 == 3'b111);
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // only R-type (op5 = 1) uses funct7b5 to select subtract
                    3'b000:  alucontrol = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control FSM for the RV32 subset datapath, with memory wait-state
// timeout, sticky trap and retired-instruction counter.
//
//   state    | meaning
//   FETCH    | read instruction at PC, PC <= PC + 4 on mem_ready
//   DECODE   | branch target into ALU-out, dispatch on opcode
//   MEMADR   | effective address rs1 + imm
//   MEMREAD  | load data, wait for mem_ready
//   MEMWB    | write load data to rd
//   MEMWRITE | store, memwrite held until mem_ready
//   EXECR    | rs1 op rs2
//   EXECI    | rs1 op imm
//   ALUWB    | write ALU-out to rd
//   BEQ      | compare, take branch on zero
//   JAL      | link = oldPC + 4, PC <= target
//   TRAP     | halted until reset
module mc_sequencer
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pcwrite,
    output logic             adrsrc,
    output logic             irwrite,
    output logic             memwrite,
    output logic             regwrite,
    output logic [1:0]       resultsrc,
    output logic [1:0]       alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       immsrc,
    output logic [2:0]       alucontrol,
    output logic             halt,
    output logic [1:0]       cause,
    output logic [CNT_W-1:0] instret
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    state_t            state, state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        cause_next;
    logic [1:0]        aluop;
    logic              legal;
    logic              retire;
    logic              mem_state;
    logic              timeout;
    logic              pcwrite_raw, irwrite_raw, memwrite_raw, regwrite_raw;

    alu_dec u_alu_dec (
        .aluop      (aluop),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .alucontrol (alucontrol),
        .legal      (legal)
    );

    assign timeout = !mem_ready && (wait_cnt == WAIT_W'(MAX_WAIT));

    always_comb begin
        state_next   = state;
        cause_next   = cause;
        retire       = 1'b0;
        mem_state    = 1'b0;
        pcwrite_raw  = 1'b0;
        irwrite_raw  = 1'b0;
        memwrite_raw = 1'b0;
        regwrite_raw = 1'b0;
        adrsrc       = 1'b0;
        resultsrc    = 2'b00;
        alusrca      = 2'b00;
        alusrcb      = 2'b00;
        aluop        = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                mem_state   = 1'b1;
                alusrcb     = 2'b10;
                resultsrc   = 2'b10;
                irwrite_raw = mem_ready;
                pcwrite_raw = mem_ready;
                if (mem_ready) begin
                    state_next = S_DECODE;
                end else if (timeout) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = legal ? S_EXECR : S_TRAP;
                    OP_I:         state_next = legal ? S_EXECI : S_TRAP;
                    OP_BEQ:       state_next = (funct3 == 3'b000) ? S_BEQ : S_TRAP;
                    OP_JAL:       state_next = S_JAL;
                    default:      state_next = S_TRAP;
                endcase
                if (state_next == S_TRAP) cause_next = CAUSE_ILLEGAL;
            end
            S_MEMADR: begin
                alusrca    = 2'b10;
                alusrcb    = 2'b01;
                state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_state = 1'b1;
                adrsrc    = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEMWB;
                end else if (timeout) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_MEMWB: begin
                resultsrc    = 2'b01;
                regwrite_raw = 1'b1;
                retire       = 1'b1;
                state_next   = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_state    = 1'b1;
                adrsrc       = 1'b1;
                memwrite_raw = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else if (timeout) begin
                    state_next = S_TRAP;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            S_EXECR: begin
                alusrca    = 2'b10;
                aluop      = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                alusrca    = 2'b10;
                alusrcb    = 2'b01;
                aluop      = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_raw = 1'b1;
                retire       = 1'b1;
                state_next   = S_FETCH;
            end
            S_BEQ: begin
                alusrca     = 2'b10;
                aluop       = ALUOP_SUB;
                pcwrite_raw = zero;
                retire      = 1'b1;
                state_next  = S_FETCH;
            end
            S_JAL: begin
                alusrca     = 2'b01;
                alusrcb     = 2'b10;
                pcwrite_raw = 1'b1;
                state_next  = S_ALUWB;
            end
            S_TRAP:  state_next = S_TRAP;
            default: state_next = S_FETCH;
        endcase
    end

    // Strobes are gated by reset so an asynchronous reset cannot pulse a write.
    assign pcwrite  = pcwrite_raw  & reset;
    assign irwrite  = irwrite_raw  & reset;
    assign memwrite = memwrite_raw & reset;
    assign regwrite = regwrite_raw & reset;
    assign immsrc   = imm_sel(op);
    assign halt     = (state == S_TRAP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FETCH;
            cause    <= CAUSE_NONE;
            wait_cnt <= '0;
            instret  <= '0;
        end else begin
            state <= state_next;
            cause <= cause_next;
            if (state_next != state) begin
                wait_cnt <= '0;
            end else if (mem_state && !mem_ready) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (retire) instret <= instret + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: per-cycle output checks against an
// instruction-level phase model, table-driven vectors, corner cases, random mix.
module tb_mc_sequencer;

    localparam int MAXW = 4;

    localparam logic [6:0] T_LW  = 7'b0000011;
    localparam logic [6:0] T_SW  = 7'b0100011;
    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_BEQ = 7'b1100011;
    localparam logic [6:0] T_JAL = 7'b1101111;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        zero;
    logic        mem_ready;
    logic        pcwrite, adrsrc, irwrite, memwrite, regwrite, halt;
    logic [1:0]  resultsrc, alusrca, alusrcb, immsrc, cause;
    logic [2:0]  alucontrol;
    logic [31:0] instret;
    logic [18:0] act;

    int errors = 0;
    int checks = 0;
    int exp_instret = 0;

    typedef enum {P_FETCH, P_DECODE, P_MEMADR, P_MEMREAD, P_MEMWB, P_MEMWRITE,
                  P_EXECR, P_EXECI, P_ALUWB, P_BEQ, P_JAL, P_TRAP} phase_t;
    phase_t plan_q[$];

    typedef struct {
        logic [6:0] o;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        int         cyc;
        bit         trap;
    } vec_t;
    vec_t tbl[14];

    mc_sequencer #(.CNT_W(32), .MAX_WAIT(MAXW)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pcwrite    (pcwrite),
        .adrsrc     (adrsrc),
        .irwrite    (irwrite),
        .memwrite   (memwrite),
        .regwrite   (regwrite),
        .resultsrc  (resultsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .immsrc     (immsrc),
        .alucontrol (alucontrol),
        .halt       (halt),
        .cause      (cause),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    assign act = {pcwrite, adrsrc, irwrite, memwrite, regwrite, resultsrc,
                  alusrca, alusrcb, alucontrol, immsrc, halt, cause};

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, a, e);
        end
    endtask

    function automatic logic [1:0] imm_exp(input logic [6:0] o);
        if (o == T_SW)  return 2'b01;
        if (o == T_BEQ) return 2'b10;
        if (o == T_JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic bit legal_exp(input logic [6:0] o, input logic [2:0] f3);
        bit f3_ok;
        f3_ok = (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
        if (o == T_R || o == T_I) return f3_ok;
        if (o == T_BEQ) return f3 == 3'b000;
        return (o == T_LW) || (o == T_SW) || (o == T_JAL);
    endfunction

    function automatic logic [2:0] alu_exp(input logic [2:0] f3, input logic f7, input logic op5);
        case (f3)
            3'b000:  return (f7 && op5) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected output word for one cycle of a given instruction phase.
    function automatic logic [18:0] expv(input phase_t ph, input logic mr, input logic z,
                                         input logic [6:0] o, input logic [2:0] f3,
                                         input logic f7, input logic [1:0] cz);
        logic       pcw, adr, irw, mw, rw, ht;
        logic [1:0] rs, sa, sb, cs;
        logic [2:0] ac;
        pcw = 0; adr = 0; irw = 0; mw = 0; rw = 0; ht = 0;
        rs = 0; sa = 0; sb = 0; cs = 0; ac = 3'b000;
        case (ph)
            P_FETCH:    begin sb = 2; rs = 2; pcw = mr; irw = mr; end
            P_DECODE:   begin sa = 1; sb = 1; end
            P_MEMADR:   begin sa = 2; sb = 1; end
            P_MEMREAD:  adr = 1;
            P_MEMWB:    begin rs = 1; rw = 1; end
            P_MEMWRITE: begin adr = 1; mw = 1; end
            P_EXECR:    begin sa = 2; ac = alu_exp(f3, f7, o[5]); end
            P_EXECI:    begin sa = 2; sb = 1; ac = alu_exp(f3, f7, o[5]); end
            P_ALUWB:    rw = 1;
            P_BEQ:      begin sa = 2; ac = 3'b001; pcw = z; end
            P_JAL:      begin sa = 1; sb = 2; pcw = 1; end
            P_TRAP:     begin ht = 1; cs = cz; end
            default:    ;
        endcase
        return {pcw, adr, irw, mw, rw, rs, sa, sb, ac, imm_exp(o), ht, cs};
    endfunction

    task automatic build_plan(input logic [6:0] o, input logic [2:0] f3);
        plan_q.delete();
        plan_q.push_back(P_FETCH);
        plan_q.push_back(P_DECODE);
        if (!legal_exp(o, f3))  plan_q.push_back(P_TRAP);
        else if (o == T_LW)     begin plan_q.push_back(P_MEMADR); plan_q.push_back(P_MEMREAD); plan_q.push_back(P_MEMWB); end
        else if (o == T_SW)     begin plan_q.push_back(P_MEMADR); plan_q.push_back(P_MEMWRITE); end
        else if (o == T_R)      begin plan_q.push_back(P_EXECR); plan_q.push_back(P_ALUWB); end
        else if (o == T_I)      begin plan_q.push_back(P_EXECI); plan_q.push_back(P_ALUWB); end
        else if (o == T_BEQ)    plan_q.push_back(P_BEQ);
        else                    begin plan_q.push_back(P_JAL); plan_q.push_back(P_ALUWB); end
    endtask

    // Call at posedge+1 with the FSM in FETCH. mode 1 randomizes mem_ready.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int mode, input phase_t stall_ph,
                             input int stall_n, output int cycles, output bit trapped);
        int         idx, wcnt, stalls;
        bit         done, is_mem;
        logic       mr;
        logic [1:0] cz;
        phase_t     ph;
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        build_plan(o, f3);
        idx = 0; wcnt = 0; stalls = 0; done = 0; cz = 2'b00;
        cycles = 0; trapped = 0;
        ph = plan_q[0];
        while (!done && cycles < 64) begin
            if (ph == stall_ph && stalls < stall_n) begin
                mr = 1'b0;
                stalls++;
            end else if (mode == 1) begin
                mr = ($urandom_range(0, 3) != 0);
            end else begin
                mr = 1'b1;
            end
            mem_ready = mr;
            @(negedge clk);
            check($sformatf("outputs op=%b f3=%b cyc%0d %s", o, f3, cycles, ph.name()),
                  32'(act), 32'(expv(ph, mr, z, o, f3, f7, cz)));
            cycles++;
            is_mem = (ph == P_FETCH) || (ph == P_MEMREAD) || (ph == P_MEMWRITE);
            if (ph == P_TRAP) begin
                done = 1; trapped = 1;
            end else if (is_mem && !mr) begin
                if (wcnt == MAXW) begin
                    ph = P_TRAP; cz = 2'b10;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
                idx++;
                if (idx == plan_q.size()) begin
                    done = 1;
                    exp_instret++;
                end else begin
                    ph = plan_q[idx];
                    if (ph == P_TRAP) cz = 2'b01;
                end
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL run_instr op=%b: still running after %0d cycles, expected completion", o, cycles);
        end else if (!trapped) begin
            check($sformatf("instret after op=%b", o), instret, 32'(exp_instret));
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mem_ready = 1'b1;
        exp_instret = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset outputs", 32'(act), 32'(expv(P_FETCH, 1'b0, zero, op, funct3, funct7b5, 2'b00)));
            check("reset instret", instret, 32'd0);
            @(posedge clk); #1;
        end
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  cyc;
        bit  trp;
        reset = 1'b0; op = T_R; funct3 = 3'b000; funct7b5 = 1'b1; zero = 1'b0; mem_ready = 1'b1;

        tbl[0]  = '{T_R,   3'b000, 1'b1, 1'b0, 4, 1'b0};
        tbl[1]  = '{T_R,   3'b000, 1'b0, 1'b0, 4, 1'b0};
        tbl[2]  = '{T_I,   3'b000, 1'b1, 1'b0, 4, 1'b0};
        tbl[3]  = '{T_R,   3'b010, 1'b0, 1'b0, 4, 1'b0};
        tbl[4]  = '{T_I,   3'b110, 1'b0, 1'b0, 4, 1'b0};
        tbl[5]  = '{T_R,   3'b111, 1'b0, 1'b0, 4, 1'b0};
        tbl[6]  = '{T_LW,  3'b010, 1'b0, 1'b0, 5, 1'b0};
        tbl[7]  = '{T_SW,  3'b010, 1'b0, 1'b0, 4, 1'b0};
        tbl[8]  = '{T_BEQ, 3'b000, 1'b0, 1'b1, 3, 1'b0};
        tbl[9]  = '{T_BEQ, 3'b000, 1'b0, 1'b0, 3, 1'b0};
        tbl[10] = '{T_JAL, 3'b000, 1'b0, 1'b0, 4, 1'b0};
        tbl[11] = '{T_R,   3'b001, 1'b0, 1'b0, 3, 1'b1};
        tbl[12] = '{T_BEQ, 3'b001, 1'b0, 1'b0, 3, 1'b1};
        tbl[13] = '{7'b1110011, 3'b000, 1'b0, 1'b0, 3, 1'b1};

        #1;
        do_reset();

        foreach (tbl[i]) begin
            run_instr(tbl[i].o, tbl[i].f3, tbl[i].f7, tbl[i].z, 0, P_TRAP, 0, cyc, trp);
            check($sformatf("vec%0d cycles", i), 32'(cyc), 32'(tbl[i].cyc));
            check($sformatf("vec%0d trapped", i), 32'(trp), 32'(tbl[i].trap));
            if (trp) do_reset();
        end

        // lw with three wait states in MEMREAD
        run_instr(T_LW, 3'b010, 1'b0, 1'b0, 0, P_MEMREAD, 3, cyc, trp);
        check("lw stall cycles", 32'(cyc), 32'd8);

        // illegal opcode: trap holds with cause 01 and all strobes low
        run_instr(7'b1110011, 3'b000, 1'b0, 1'b0, 0, P_TRAP, 0, cyc, trp);
        check("illegal trapped", 32'(trp), 32'd1);
        for (int i = 0; i < 10; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            zero = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("trap hold", 32'(act), 32'(expv(P_TRAP, mem_ready, zero, op, funct3, funct7b5, 2'b01)));
            check("trap instret", instret, 32'(exp_instret));
            @(posedge clk); #1;
        end
        do_reset();

        // fetch timeout vs. completion exactly at the limit
        run_instr(T_R, 3'b000, 1'b0, 1'b0, 0, P_FETCH, MAXW + 1, cyc, trp);
        check("fetch timeout trapped", 32'(trp), 32'd1);
        check("fetch timeout cycles", 32'(cyc), 32'(MAXW + 2));
        do_reset();
        run_instr(T_R, 3'b000, 1'b0, 1'b0, 0, P_FETCH, MAXW, cyc, trp);
        check("fetch at limit trapped", 32'(trp), 32'd0);
        check("fetch at limit cycles", 32'(cyc), 32'(MAXW + 4));
        run_instr(T_SW, 3'b010, 1'b0, 1'b0, 0, P_MEMWRITE, MAXW + 1, cyc, trp);
        check("store timeout trapped", 32'(trp), 32'd1);
        do_reset();

        // asynchronous reset while a store strobe is high
        op = T_SW; funct3 = 3'b010; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        #2;
        check("store strobe before reset", 32'(memwrite), 32'd1);
        reset = 1'b0;
        #1;
        check("async reset outputs", 32'(act), 32'(expv(P_FETCH, 1'b0, zero, op, funct3, funct7b5, 2'b00)));
        @(posedge clk); #1;
        do_reset();

        // random instruction mix with random wait states
        for (int n = 0; n < 80; n++) begin
            logic [6:0] o;
            logic [2:0] f3;
            int k;
            k = $urandom_range(0, 9);
            f3 = 3'($urandom_range(0, 7));
            case (k)
                0: o = T_LW;
                1: o = T_SW;
                2: o = T_R;
                3: o = T_I;
                4: begin o = T_BEQ; f3 = 3'b000; end
                5: o = T_JAL;
                6: o = T_R;
                7: o = T_I;
                8: o = T_BEQ;
                default: o = 7'($urandom_range(0, 127));
            endcase
            if (k == 2 || k == 3) f3 = (f3[0]) ? 3'b110 : 3'b000;
            run_instr(o, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, P_TRAP, 0, cyc, trp);
            if (trp) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
